mem_xbar: RTL and testbench



---
 rtl/mem_xbar.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_mem_xbar.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xbar.sv
// mem_xbar: AXI-lite 1-to-2 address-decoding crossbar.
//
// A single upstream master (the memory arbiter) is routed to one of two
// slaves: slave 0 is main SRAM and slave 1 is the device window (UART/CLINT).
// Only one transaction is in flight at a time. The route is chosen in IDLE
// from the request address. It stays locked from the address handshake until
// the response handshake. All forwarding is combinational, so no latency is
// added on either path.
//
// Compile-time option:
//   MEM_XBAR_DECERR_EN - when defined, addresses outside both windows are
//                        answered locally with DECERR (2'b11). When undefined,
//                        such addresses fall through to slave 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   m_ar*/m_r*            master read address / read data channels
//   m_aw*/m_w*/m_b*       master write address / write data / write response
//   s0_*, s1_*            the same five channels toward slave 0 / slave 1
//
// Parameters:
//   SRAM_BASE/SRAM_SIZE   slave 0 window; the size is a power of two
//   DEV_BASE/DEV_SIZE     slave 1 window; the size is a power of two
module mem_xbar #(
    parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
    parameter logic [31:0] SRAM_SIZE = 32'h0800_0000,
    parameter logic [31:0] DEV_BASE  = 32'ha000_0000,
    parameter logic [31:0] DEV_SIZE  = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        rst,
    // master side
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [7:0]  m_wstrb,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    // slave 0 (SRAM)
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s0_awaddr,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [7:0]  s0_wstrb,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    // slave 1 (device window)
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    output logic [31:0] s1_awaddr,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [7:0]  s1_wstrb,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready
);

`ifdef MEM_XBAR_DECERR_EN
    typedef enum logic [2:0] {
        IDLE, RD_S0, RD_S1, RD_ERR, WR_S0, WR_S1, WR_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, RD_S0, RD_S1, WR_S0, WR_S1
    } state_t;
`endif

    localparam logic [1:0] TGT_S0  = 2'd0;
    localparam logic [1:0] TGT_S1  = 2'd1;
`ifdef MEM_XBAR_DECERR_EN
    localparam logic [1:0] TGT_ERR = 2'd2;
`endif

    state_t     state_reg;
    logic [1:0] rd_tgt;
    logic [1:0] wr_tgt;

    // Window hit test: unsigned wrap-around subtraction, so an address below
    // the base wraps to a huge offset and misses. The device window is checked
    // first, so it wins if the windows overlap.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        logic [31:0] off_s0;
        logic [31:0] off_s1;
        logic [1:0]  tgt;
        off_s0 = addr - SRAM_BASE;
        off_s1 = addr - DEV_BASE;
        if (off_s1 < DEV_SIZE) begin
            tgt = TGT_S1;
        end else if (off_s0 < SRAM_SIZE) begin
            tgt = TGT_S0;
        end else begin
`ifdef MEM_XBAR_DECERR_EN
            tgt = TGT_ERR;
`else
            tgt = TGT_S0;
`endif
        end
        return tgt;
    endfunction

    // The decode is re-evaluated every cycle. It only matters in IDLE.
    assign rd_tgt = decode(m_araddr);
    assign wr_tgt = decode(m_awaddr);

    // Combinational routing. Everything defaults to zero, so an unselected
    // slave sees all-zero inputs. Reset forces every output low, even though
    // the master inputs may still be active.
    always_comb begin
        m_arready  = 1'b0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rvalid   = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bresp    = '0;
        m_bvalid   = 1'b0;
        s0_araddr  = '0;
        s0_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s0_awaddr  = '0;
        s0_awvalid = 1'b0;
        s0_wdata   = '0;
        s0_wstrb   = '0;
        s0_wvalid  = 1'b0;
        s0_bready  = 1'b0;
        s1_araddr  = '0;
        s1_arvalid = 1'b0;
        s1_rready  = 1'b0;
        s1_awaddr  = '0;
        s1_awvalid = 1'b0;
        s1_wdata   = '0;
        s1_wstrb   = '0;
        s1_wvalid  = 1'b0;
        s1_bready  = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    // A pending read blocks the write entirely. Both write
                    // readies stay low until the read has completed.
                    if (m_arvalid) begin
                        case (rd_tgt)
                            TGT_S0: begin
                                s0_arvalid = 1'b1;
                                s0_araddr  = m_araddr;
                                m_arready  = s0_arready;
                            end
                            TGT_S1: begin
                                s1_arvalid = 1'b1;
                                s1_araddr  = m_araddr;
                                m_arready  = s1_arready;
                            end
                            default: begin
`ifdef MEM_XBAR_DECERR_EN
                                m_arready = 1'b1;
`endif
                            end
                        endcase
                    end else if (m_awvalid && m_wvalid) begin
                        // The AW and W channels are accepted together, so
                        // the master sees a single joint handshake.
                        case (wr_tgt)
                            TGT_S0: begin
                                s0_awvalid = 1'b1;
                                s0_awaddr  = m_awaddr;
                                s0_wvalid  = 1'b1;
                                s0_wdata   = m_wdata;
                                s0_wstrb   = m_wstrb;
                                m_awready  = s0_awready & s0_wready;
                                m_wready   = s0_awready & s0_wready;
                            end
                            TGT_S1: begin
                                s1_awvalid = 1'b1;
                                s1_awaddr  = m_awaddr;
                                s1_wvalid  = 1'b1;
                                s1_wdata   = m_wdata;
                                s1_wstrb   = m_wstrb;
                                m_awready  = s1_awready & s1_wready;
                                m_wready   = s1_awready & s1_wready;
                            end
                            default: begin
`ifdef MEM_XBAR_DECERR_EN
                                m_awready = 1'b1;
                                m_wready  = 1'b1;
`endif
                            end
                        endcase
                    end
                end
                RD_S0: begin
                    m_rdata   = s0_rdata;
                    m_rresp   = s0_rresp;
                    m_rvalid  = s0_rvalid;
                    s0_rready = m_rready;
                end
                RD_S1: begin
                    m_rdata   = s1_rdata;
                    m_rresp   = s1_rresp;
                    m_rvalid  = s1_rvalid;
                    s1_rready = m_rready;
                end
                WR_S0: begin
                    m_bresp   = s0_bresp;
                    m_bvalid  = s0_bvalid;
                    s0_bready = m_bready;
                end
                WR_S1: begin
                    m_bresp   = s1_bresp;
                    m_bvalid  = s1_bvalid;
                    s1_bready = m_bready;
                end
`ifdef MEM_XBAR_DECERR_EN
                RD_ERR: begin
                    m_rvalid = 1'b1;
                    m_rresp  = 2'b11;
                end
                WR_ERR: begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b11;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Route lock: the state moves on the master-side handshakes. It leaves
    // IDLE on the address handshake and returns on the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_arvalid && m_arready) begin
                        case (rd_tgt)
                            TGT_S0:  state_reg <= RD_S0;
                            TGT_S1:  state_reg <= RD_S1;
`ifdef MEM_XBAR_DECERR_EN
                            default: state_reg <= RD_ERR;
`else
                            default: state_reg <= RD_S0;
`endif
                        endcase
                    end else if (m_awvalid && m_wvalid && m_awready) begin
                        case (wr_tgt)
                            TGT_S0:  state_reg <= WR_S0;
                            TGT_S1:  state_reg <= WR_S1;
`ifdef MEM_XBAR_DECERR_EN
                            default: state_reg <= WR_ERR;
`else
                            default: state_reg <= WR_S0;
`endif
                        endcase
                    end
                end
`ifdef MEM_XBAR_DECERR_EN
                RD_S0, RD_S1, RD_ERR: begin
`else
                RD_S0, RD_S1: begin
`endif
                    if (m_rvalid && m_rready) begin
                        state_reg <= IDLE;
                    end
                end
`ifdef MEM_XBAR_DECERR_EN
                WR_S0, WR_S1, WR_ERR: begin
`else
                WR_S0, WR_S1: begin
`endif
                    if (m_bvalid && m_bready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_xbar.sv
// tb_mem_xbar: directed self-checking bench for mem_xbar. The bench drives
// both slave ports directly and checks the combinational routing and the
// route lock cycle by cycle. It covers both builds of MEM_XBAR_DECERR_EN.
module tb_mem_xbar;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [7:0]  m_wstrb;
    logic [31:0] s0_araddr, s0_rdata, s0_awaddr, s0_wdata;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic [1:0]  s0_rresp, s0_bresp;
    logic [7:0]  s0_wstrb;
    logic [31:0] s1_araddr, s1_rdata, s1_awaddr, s1_wdata;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic [1:0]  s1_rresp, s1_bresp;
    logic [7:0]  s1_wstrb;

    int total = 0;
    int bad   = 0;

    mem_xbar dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready)
    );

    always #5 clk = ~clk;

    // Any activity toward a slave, OR-reduced: it must be 0 whenever that
    // slave is not selected.
    logic s0_any, s1_any;
    assign s0_any = |{s0_araddr, s0_arvalid, s0_rready, s0_awaddr, s0_awvalid,
                      s0_wdata, s0_wstrb, s0_wvalid, s0_bready};
    assign s1_any = |{s1_araddr, s1_arvalid, s1_rready, s1_awaddr, s1_awvalid,
                      s1_wdata, s1_wstrb, s1_wvalid, s1_bready};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Address decode table. With DECERR off, unmapped addresses go to s0.
    logic [31:0] dec_addr [6];
    logic        dec_s0   [6];
    logic        dec_s1   [6];
`ifdef MEM_XBAR_DECERR_EN
    localparam logic UNM_S0 = 1'b0;
`else
    localparam logic UNM_S0 = 1'b1;
`endif

    int hs_cnt;

    initial begin
        dec_addr[0] = 32'h8000_0000; dec_s0[0] = 1'b1;   dec_s1[0] = 1'b0;
        dec_addr[1] = 32'h87ff_fffc; dec_s0[1] = 1'b1;   dec_s1[1] = 1'b0;
        dec_addr[2] = 32'h8800_0000; dec_s0[2] = UNM_S0; dec_s1[2] = 1'b0;
        dec_addr[3] = 32'ha0ff_ffff; dec_s0[3] = 1'b0;   dec_s1[3] = 1'b1;
        dec_addr[4] = 32'ha100_0000; dec_s0[4] = UNM_S0; dec_s1[4] = 1'b0;
        dec_addr[5] = 32'h7fff_fffc; dec_s0[5] = UNM_S0; dec_s1[5] = 1'b0;

        rst = 1'b1;
        m_araddr = 32'h8000_0010; m_arvalid = 1'b1; m_rready = 1'b1;
        m_awaddr = 32'ha000_0000; m_awvalid = 1'b1; m_wdata = 32'h55; m_wstrb = 8'h1;
        m_wvalid = 1'b1; m_bready = 1'b1;
        s0_arready = 1'b1; s0_rdata = 32'h1111_1111; s0_rresp = 2'b0; s0_rvalid = 1'b1;
        s0_awready = 1'b1; s0_wready = 1'b1; s0_bresp = 2'b0; s0_bvalid = 1'b1;
        s1_arready = 1'b1; s1_rdata = 32'h2222_2222; s1_rresp = 2'b0; s1_rvalid = 1'b1;
        s1_awready = 1'b1; s1_wready = 1'b1; s1_bresp = 2'b0; s1_bvalid = 1'b1;

        // While reset is high, the outputs stay 0 even with active inputs.
        tick(); tick();
        check("rst_m_arready", 32'(m_arready), 32'd0);
        check("rst_m_awready", 32'(m_awready), 32'd0);
        check("rst_m_rvalid", 32'(m_rvalid), 32'd0);
        check("rst_m_bvalid", 32'(m_bvalid), 32'd0);
        check("rst_s0_any", 32'(s0_any), 32'd0);
        check("rst_s1_any", 32'(s1_any), 32'd0);

        m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; m_rready = 1'b0; m_bready = 1'b0;
        s0_rvalid = 1'b0; s0_bvalid = 1'b0; s1_rvalid = 1'b0; s1_bvalid = 1'b0;
        rst = 1'b0;
        tick();

        // Decode table: check the route only. The request is withdrawn
        // before the next edge, so no handshake takes place.
        for (int i = 0; i < 6; i++) begin
            m_araddr = dec_addr[i]; m_arvalid = 1'b1;
            settle();
            check($sformatf("dec%0d_s0", i), 32'(s0_arvalid), 32'(dec_s0[i]));
            check($sformatf("dec%0d_s1", i), 32'(s1_arvalid), 32'(dec_s1[i]));
            m_arvalid = 1'b0;
            settle();
        end
        tick();

        // T1: read 0x8000_0010 from s0. The data arrives after 3 stall cycles.
        m_araddr = 32'h8000_0010; m_arvalid = 1'b1;
        settle();
        check("t1_s0_arvalid", 32'(s0_arvalid), 32'd1);
        check("t1_s0_araddr", s0_araddr, 32'h8000_0010);
        check("t1_m_arready", 32'(m_arready), 32'd1);
        check("t1_s1_any", 32'(s1_any), 32'd0);
        tick();
        m_arvalid = 1'b0; m_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t1_stall%0d_rvalid", i), 32'(m_rvalid), 32'd0);
            tick();
        end
        s0_rvalid = 1'b1; s0_rdata = 32'hdead_beef; s0_rresp = 2'b00;
        settle();
        check("t1_m_rvalid", 32'(m_rvalid), 32'd1);
        check("t1_m_rdata", m_rdata, 32'hdead_beef);
        check("t1_m_rresp", 32'(m_rresp), 32'd0);
        check("t1_s0_rready", 32'(s0_rready), 32'd1);
        check("t1_s1_any_r", 32'(s1_any), 32'd0);
        tick();
        s0_rvalid = 1'b0; m_rready = 1'b0;
        // If the FSM is back in IDLE, a new request is forwarded at once.
        m_araddr = 32'h8000_0020; m_arvalid = 1'b1;
        settle();
        check("t1_idle_arready", 32'(m_arready), 32'd1);
        check("t1_idle_rvalid", 32'(m_rvalid), 32'd0);
        m_arvalid = 1'b0;
        tick();

        // T2: write to s1. The handshake needs both the aw and w readies.
        m_awaddr = 32'ha000_03f8; m_wdata = 32'h41; m_wstrb = 8'h01;
        m_awvalid = 1'b1; m_wvalid = 1'b1; s1_awready = 1'b1; s1_wready = 1'b0;
        settle();
        check("t2_part_awready", 32'(m_awready), 32'd0);
        check("t2_part_wready", 32'(m_wready), 32'd0);
        s1_wready = 1'b1;
        settle();
        check("t2_s1_awvalid", 32'(s1_awvalid), 32'd1);
        check("t2_s1_awaddr", s1_awaddr, 32'ha000_03f8);
        check("t2_s1_wdata", s1_wdata, 32'h41);
        check("t2_s1_wstrb", 32'(s1_wstrb), 32'h1);
        check("t2_m_awready", 32'(m_awready), 32'd1);
        check("t2_m_wready", 32'(m_wready), 32'd1);
        check("t2_s0_any", 32'(s0_any), 32'd0);
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b1;
        settle();
        check("t2_bvalid_lo", 32'(m_bvalid), 32'd0);
        check("t2_s1_bready", 32'(s1_bready), 32'd1);
        tick();
        s1_bvalid = 1'b1; s1_bresp = 2'b10;
        settle();
        check("t2_m_bvalid", 32'(m_bvalid), 32'd1);
        check("t2_m_bresp", 32'(m_bresp), 32'd2);
        check("t2_s0_any_b", 32'(s0_any), 32'd0);
        tick();
        s1_bvalid = 1'b0; s1_bresp = 2'b00; m_bready = 1'b0;
        tick();

        // T3: a read and a write arrive together. The read wins and the
        // write waits for the IDLE bubble.
        m_araddr = 32'h8000_0000; m_arvalid = 1'b1;
        m_awaddr = 32'ha000_0000; m_wdata = 32'h77; m_wstrb = 8'h0f;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        settle();
        check("t3_s0_arvalid", 32'(s0_arvalid), 32'd1);
        check("t3_s1_awvalid", 32'(s1_awvalid), 32'd0);
        check("t3_m_awready", 32'(m_awready), 32'd0);
        check("t3_m_wready", 32'(m_wready), 32'd0);
        tick();
        m_arvalid = 1'b0;
        settle();
        check("t3_rd_s1_awvalid", 32'(s1_awvalid), 32'd0);
        s0_rvalid = 1'b1; s0_rdata = 32'hcafe_0001; m_rready = 1'b1;
        settle();
        check("t3_m_rdata", m_rdata, 32'hcafe_0001);
        tick();
        s0_rvalid = 1'b0; m_rready = 1'b0;
        settle();
        check("t3_bubble_awvalid", 32'(s1_awvalid), 32'd1);
        check("t3_bubble_awready", 32'(m_awready), 32'd1);
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        s1_bvalid = 1'b1; m_bready = 1'b1;
        settle();
        check("t3_m_bvalid", 32'(m_bvalid), 32'd1);
        tick();
        s1_bvalid = 1'b0; m_bready = 1'b0;
        tick();

        // T4: unmapped read.
        m_araddr = 32'h0000_1000; m_arvalid = 1'b1; s0_arready = 1'b0;
        settle();
`ifdef MEM_XBAR_DECERR_EN
        check("t4_m_arready", 32'(m_arready), 32'd1);
        check("t4_s0_any", 32'(s0_any), 32'd0);
        check("t4_s1_any", 32'(s1_any), 32'd0);
        tick();
        m_arvalid = 1'b0; m_rready = 1'b1;
        settle();
        check("t4_m_rvalid", 32'(m_rvalid), 32'd1);
        check("t4_m_rresp", 32'(m_rresp), 32'd3);
        check("t4_m_rdata", m_rdata, 32'd0);
        tick();
        m_rready = 1'b0;
        s0_arready = 1'b1;
`else
        check("t4_s0_arvalid", 32'(s0_arvalid), 32'd1);
        check("t4_s0_araddr", s0_araddr, 32'h0000_1000);
        check("t4_m_arready_stall", 32'(m_arready), 32'd0);
        s0_arready = 1'b1;
        settle();
        check("t4_m_arready", 32'(m_arready), 32'd1);
        tick();
        m_arvalid = 1'b0; m_rready = 1'b1; s0_rvalid = 1'b1; s0_rdata = 32'h0bad_0bad;
        settle();
        check("t4_m_rdata", m_rdata, 32'h0bad_0bad);
        tick();
        s0_rvalid = 1'b0; m_rready = 1'b0;
`endif
        tick();

        // T5: s1 stalls for 10 cycles with rready toggling. A competing
        // request stays pending and must not be accepted.
        m_araddr = 32'ha000_0004; m_arvalid = 1'b1;
        settle();
        check("t5_s1_arvalid", 32'(s1_arvalid), 32'd1);
        tick();
        m_araddr = 32'h8000_0040;
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            m_rready = i[0];
            settle();
            check($sformatf("t5_stall%0d_arready", i), 32'(m_arready), 32'd0);
            if (m_rvalid && m_rready) hs_cnt++;
            tick();
        end
        check("t5_s0_arvalid_stall", 32'(s0_arvalid), 32'd0);
        s1_rvalid = 1'b1; s1_rdata = 32'h1234_5678; m_rready = 1'b1; m_arvalid = 1'b0;
        settle();
        check("t5_m_rdata", m_rdata, 32'h1234_5678);
        if (m_rvalid && m_rready) hs_cnt++;
        tick();
        // The slave keeps rvalid high, but the route is released and
        // the data must not be delivered a second time.
        settle();
        if (m_rvalid && m_rready) hs_cnt++;
        check("t5_handshakes", 32'(hs_cnt), 32'd1);
        s1_rvalid = 1'b0; m_rready = 1'b0;
        tick();

        // T6: reset arrives in WR_S0 while s0_bvalid is low.
        m_awaddr = 32'h8000_0100; m_wdata = 32'h99; m_wstrb = 8'hff;
        m_awvalid = 1'b1; m_wvalid = 1'b1;
        settle();
        check("t6_m_awready", 32'(m_awready), 32'd1);
        tick();
        m_bready = 1'b1;
        settle();
        check("t6_wr_s0_bready", 32'(s0_bready), 32'd1);
        rst = 1'b1;
        settle();
        check("t6_rst_s0_bready", 32'(s0_bready), 32'd0);
        check("t6_rst_s0_any", 32'(s0_any), 32'd0);
        check("t6_rst_m_awready", 32'(m_awready), 32'd0);
        tick();
        rst = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
        m_araddr = 32'h8000_0200; m_arvalid = 1'b1; s0_arready = 1'b1;
        settle();
        check("t6_after_arready", 32'(m_arready), 32'd1);
        check("t6_after_s0_araddr", s0_araddr, 32'h8000_0200);
        tick();
        m_arvalid = 1'b0; s0_rvalid = 1'b1; s0_rdata = 32'h600d_600d; m_rready = 1'b1;
        settle();
        check("t6_after_rdata", m_rdata, 32'h600d_600d);
        tick();
        s0_rvalid = 1'b0; m_rready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
